decoder_scan_controller: RTL and testbench

DECODER_SCAN_CONTROLLER -- requirements
Module: decoder_scan_controller

---
 rtl/decoder_pkg.sv | 21 ++
 rtl/decoder_scan_controller_scan_timer.sv | 33 +++
 rtl/decoder_scan_controller.sv | 166 ++++++++++++++++
 tb/tb_decoder_scan_controller.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared definitions for the digit scan controller: FSM encoding, default
// parameter values and the counter-width helper.
package decoder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } scan_state_e;

    localparam int DEF_WORD_LENGTH  = 5;
    localparam int DEF_DIGITS       = 4;
    localparam int DEF_DWELL        = 1000;
    localparam int DEF_BLANK_CYCLES = 2;

    // Bits needed to count 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/decoder_scan_controller_scan_timer.sv
// Phase timer: counts while run_i is high and flags the cycle in which the
// count reaches tc_i, then restarts from zero.
module scan_timer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         run_i,
    input  logic [W-1:0] tc_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q, cnt_d;

    assign done_o = run_i && (cnt_q == tc_i);

    // Any cycle without run_i or ending a phase leaves the next phase at zero.
    always_comb begin
        cnt_d = '0;
        if (run_i && !done_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/decoder_scan_controller.sv
// Time-multiplexed digit scanner with a double-buffered code store; new codes
// reach the display only at a frame boundary (or while idle).
module decoder_scan_controller
    import decoder_pkg::*;
#(
    parameter int WORD_LENGTH  = DEF_WORD_LENGTH,
    parameter int DIGITS       = DEF_DIGITS,
    parameter int DWELL        = DEF_DWELL,
    parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          Enable,
    input  logic                          Load,
    input  logic [DIGITS*WORD_LENGTH-1:0] Data_Input,
    output logic                          Load_Ack,
    output logic [WORD_LENGTH-1:0]        Dec_Data,
    output logic [DIGITS-1:0]             Digit_Enable,
    output logic                          Frame_Done
);

    localparam int DATA_W = DIGITS * WORD_LENGTH;
    localparam int IDX_W  = cnt_width(DIGITS);
    localparam int TMR_W  = cnt_width((DWELL > BLANK_CYCLES) ? DWELL : BLANK_CYCLES);

    localparam logic [TMR_W-1:0] DWELL_TC = TMR_W'(DWELL - 1);
    localparam logic [TMR_W-1:0] BLANK_TC = TMR_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
    localparam logic [DIGITS-1:0] ONE_HOT0 = {{(DIGITS-1){1'b0}}, 1'b1};

    scan_state_e        state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]  shadow_q, shadow_d;
    logic [DATA_W-1:0]  active_q, active_d;
    logic               pending_q, pending_d;
    logic [WORD_LENGTH-1:0] dec_q, dec_d;
    logic [DIGITS-1:0]  digen_q, digen_d;
    logic               ack_q;
    logic               frame_q, frame_d;

    logic               step;
    logic               copy;
    logic               tmr_run;
    logic               tmr_done;
    logic [TMR_W-1:0]   tmr_tc;

    assign tmr_run = Enable && (state_q != IDLE);
    assign tmr_tc  = (state_q == BLANK) ? BLANK_TC : DWELL_TC;

    scan_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .run_i  (tmr_run),
        .tc_i   (tmr_tc),
        .done_o (tmr_done)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        frame_d   = 1'b0;
        step      = 1'b0;
        copy      = 1'b0;

        case (state_q)
            IDLE: begin
                copy = pending_q;
                if (Enable) begin
                    state_d = SHOW;
                    idx_d   = '0;
                end
            end
            SHOW: begin
                if (!Enable) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else if (tmr_done) begin
                    if (BLANK_CYCLES > 0) begin
                        state_d = BLANK;
                    end else begin
                        step = 1'b1;
                    end
                end
            end
            BLANK: begin
                if (!Enable) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else if (tmr_done) begin
                    step = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase

        // Advancing past the last digit closes the frame: the only point
        // (besides idle) where pending codes may replace the displayed ones.
        if (step) begin
            state_d = SHOW;
            if (idx_q == LAST_IDX) begin
                idx_d   = '0;
                frame_d = 1'b1;
                copy    = pending_q;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end

        // A capture on the copy edge re-arms pending with the newer value.
        if (copy) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end
        if (Load) begin
            shadow_d  = Data_Input;
            pending_d = 1'b1;
        end

        dec_d   = '0;
        digen_d = '0;
        if (state_d != IDLE) begin
            dec_d = active_d[idx_d*WORD_LENGTH +: WORD_LENGTH];
        end
        if (state_d == SHOW) begin
            digen_d = ONE_HOT0 << idx_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            shadow_q  <= '0;
            active_q  <= '0;
            pending_q <= 1'b0;
            dec_q     <= '0;
            digen_q   <= '0;
            ack_q     <= 1'b0;
            frame_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            dec_q     <= dec_d;
            digen_q   <= digen_d;
            ack_q     <= Load;
            frame_q   <= frame_d;
        end
    end

    assign Load_Ack     = ack_q;
    assign Dec_Data     = dec_q;
    assign Digit_Enable = digen_q;
    assign Frame_Done   = frame_q;

endmodule

// File: tb/tb_decoder_scan_controller.sv
// Bench for decoder_scan_controller: one instance with a one-cycle blank gap and
// one with no gap, both with 4 digits of 5-bit codes and a 4-cycle dwell.
module tb_decoder_scan_controller;

    localparam int WL = 5;
    localparam int ND = 4;
    localparam int DW = 4;

    logic clk = 1'b0;
    logic reset;

    logic        en_a, ld_a, ack_a, fd_a;
    logic [19:0] din_a;
    logic [4:0]  dec_a;
    logic [3:0]  den_a;

    logic        en_b, ld_b, ack_b, fd_b;
    logic [19:0] din_b;
    logic [4:0]  dec_b;
    logic [3:0]  den_b;

    always #5 clk = ~clk;

    decoder_scan_controller #(
        .WORD_LENGTH(WL), .DIGITS(ND), .DWELL(DW), .BLANK_CYCLES(1)
    ) dut_a (
        .clk(clk), .reset(reset), .Enable(en_a), .Load(ld_a), .Data_Input(din_a),
        .Load_Ack(ack_a), .Dec_Data(dec_a), .Digit_Enable(den_a), .Frame_Done(fd_a)
    );

    decoder_scan_controller #(
        .WORD_LENGTH(WL), .DIGITS(ND), .DWELL(DW), .BLANK_CYCLES(0)
    ) dut_b (
        .clk(clk), .reset(reset), .Enable(en_b), .Load(ld_b), .Data_Input(din_b),
        .Load_Ack(ack_b), .Dec_Data(dec_b), .Digit_Enable(den_b), .Frame_Done(fd_b)
    );

    typedef struct {
        bit          sel;   // 0: gapped instance, 1: gapless instance
        bit          en;
        bit          ld;
        logic [19:0] data;
        logic [3:0]  den;
        logic [4:0]  dec;
        bit          fd;
        bit          ack;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   tests = 0;
    int   fails = 0;

    function automatic logic [19:0] pack4(input int c0, input int c1, input int c2, input int c3);
        return {5'(c3), 5'(c2), 5'(c1), 5'(c0)};
    endfunction

    function automatic void add(input bit sel, input bit en, input bit ld, input logic [19:0] data,
                                input logic [3:0] den, input logic [4:0] dec, input bit fd);
        vec_t v;
        v.sel = sel; v.en = en; v.ld = ld; v.data = data;
        v.den = den; v.dec = dec; v.fd = fd; v.ack = ld;
        vecs.push_back(v);
    endfunction

    // n cycles of a running frame; cycle 0 is the first cycle digit 0 is lit.
    function automatic void add_frame(input bit sel, input int blank, input logic [19:0] codes,
                                      input bit fd, input int ld_cyc, input logic [19:0] ld_data,
                                      input int n);
        int p;
        p = DW + blank;
        for (int c = 0; c < n; c++) begin
            int d;
            int o;
            d = c / p;
            o = c % p;
            add(sel, 1'b1, (c == ld_cyc), ld_data, (o < DW) ? 4'(1 << d) : 4'd0,
                codes[d*WL +: WL], fd && (c == 0));
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_vecs();
        vec_t v;
        vec_t e;
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            en_a = 1'b0; ld_a = 1'b0; din_a = '0;
            en_b = 1'b0; ld_b = 1'b0; din_b = '0;
            if (v.sel) begin
                en_b = v.en; ld_b = v.ld; din_b = v.data;
            end else begin
                en_a = v.en; ld_a = v.ld; din_a = v.data;
            end
            sb.push_back(v);
            tick();
            e = sb.pop_front();
            if (e.sel) begin
                chk($sformatf("b%0d.den", i), den_b, e.den);
                chk($sformatf("b%0d.dec", i), dec_b, e.dec);
                chk($sformatf("b%0d.fd", i),  fd_b,  e.fd);
                chk($sformatf("b%0d.ack", i), ack_b, e.ack);
            end else begin
                chk($sformatf("a%0d.den", i), den_a, e.den);
                chk($sformatf("a%0d.dec", i), dec_a, e.dec);
                chk($sformatf("a%0d.fd", i),  fd_a,  e.fd);
                chk($sformatf("a%0d.ack", i), ack_a, e.ack);
            end
        end
        vecs.delete();
    endtask

    initial begin
        logic [19:0] cA, cB, cC, cD, cE;
        cA = pack4(1, 2, 3, 4);
        cB = pack4(9, 9, 9, 9);
        cC = pack4(10, 11, 12, 13);
        cD = pack4(5, 6, 7, 8);
        cE = pack4(7, 3, 15, 21);

        reset = 1'b1;
        en_a = 1'b0; ld_a = 1'b0; din_a = '0;
        en_b = 1'b0; ld_b = 1'b0; din_b = '0;
        tick();
        tick();
        chk("rst.den_a", den_a, 0); chk("rst.dec_a", dec_a, 0);
        chk("rst.fd_a", fd_a, 0);   chk("rst.ack_a", ack_a, 0);
        chk("rst.den_b", den_b, 0); chk("rst.dec_b", dec_b, 0);
        chk("rst.fd_b", fd_b, 0);   chk("rst.ack_b", ack_b, 0);
        reset = 1'b0;

        // Gapped instance: load, full frames, mid-frame load, load on the
        // wrap edge, then Enable dropped in the last blank and re-enabled.
        add(0, 0, 1, cA, 0, 0, 0);
        add_frame(0, 1, cA, 0, -1, '0, 20);
        add_frame(0, 1, cA, 1, 11, cB, 20);
        add_frame(0, 1, cB, 1, 5, cD, 20);
        add_frame(0, 1, cD, 1, 0, cC, 20);
        add_frame(0, 1, cC, 1, -1, '0, 20);
        for (int k = 0; k < 3; k++) add(0, 0, 0, '0, 0, 0, 0);
        add_frame(0, 1, cC, 0, -1, '0, 20);
        add_frame(0, 1, cC, 1, -1, '0, 1);
        run_vecs();

        // Asynchronous reset while digit 1 is lit.
        en_a = 1'b0; ld_a = 1'b0;
        tick();
        en_a = 1'b1;
        for (int k = 0; k < 7; k++) tick();
        chk("arst.pre_den", den_a, 4'b0010);
        chk("arst.pre_dec", dec_a, 11);
        #2 reset = 1'b1;
        #1;
        chk("arst.den", den_a, 0); chk("arst.dec", dec_a, 0);
        chk("arst.fd", fd_a, 0);   chk("arst.ack", ack_a, 0);
        tick();
        chk("arst.hold_den", den_a, 0); chk("arst.hold_fd", fd_a, 0);
        reset = 1'b0;
        tick();
        chk("arst.restart_den", den_a, 4'b0001);
        chk("arst.cleared_dec0", dec_a, 0);
        for (int k = 0; k < 5; k++) tick();
        chk("arst.d1_den", den_a, 4'b0010);
        chk("arst.cleared_dec1", dec_a, 0);

        // First Load right after reset release is captured on the first edge.
        en_a = 1'b0;
        tick();
        reset = 1'b1;
        #2 reset = 1'b0;
        ld_a = 1'b1; din_a = cB;
        tick();
        chk("first_load.ack", ack_a, 1);
        ld_a = 1'b0;
        tick();
        chk("first_load.ack_off", ack_a, 0);

        // Gapless instance: digits back to back, Frame_Done every 16 cycles.
        add(1, 0, 1, cE, 0, 0, 0);
        add_frame(1, 0, cE, 0, -1, '0, 16);
        add_frame(1, 0, cE, 1, -1, '0, 16);
        add_frame(1, 0, cE, 1, -1, '0, 1);
        add(1, 0, 0, '0, 0, 0, 0);
        run_vecs();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
